blk_sched: RTL and testbench

- Thread scheduler in front of create_blk in the sha512unit.
- Picks one thread at a time, round-robin, from threads that have a pending procb record.
- Issues a one-cycle blk_start with thread_num, new_comp and blk_op, then holds until create_blk reports blk_end.
- Gates issue on credits for free block slots in the downstream SHA-512 core input buffer.

---
 rtl/blk_sched_pkg.sv | 19 +
 rtl/blk_sched_if.sv | 24 ++
 rtl/blk_sched_rr_arbiter.sv | 30 +++
 rtl/blk_sched.sv | 171 +++++++++++++++++
 tb/tb_blk_sched.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/blk_sched_pkg.sv
// rtl/blk_sched_pkg.sv - shared constants, state encoding and helpers for the block scheduler
package blk_sched_pkg;

    localparam int BLK_OP_MSB      = 2;
    localparam int DEF_N_BLK_SLOTS = 2;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_SELECT    = 2'd1,
        ST_START     = 2'd2,
        ST_ACTIVE    = 2'd3
    } blk_sched_state_t;

    // Index of the most significant set bit needed to hold value v.
    function automatic int msb_of(input int v);
        return (v < 1) ? 0 : $clog2(v + 1) - 1;
    endfunction

endpackage

// File: rtl/blk_sched_if.sv
// rtl/blk_sched_if.sv - start/end handshake between the scheduler and create_blk
interface blk_sched_if
    import blk_sched_pkg::*;
#(
    parameter int THREAD_MSB = 3,
    parameter int OP_MSB     = BLK_OP_MSB
);
    logic                blk_start;
    logic                new_comp;
    logic [THREAD_MSB:0] thread_num;
    logic [OP_MSB:0]     blk_op;
    logic                cblk_full;
    logic                cblk_blk_end;

    modport master (
        output blk_start, new_comp, thread_num, blk_op,
        input  cblk_full, cblk_blk_end
    );

    modport slave (
        input  blk_start, new_comp, thread_num, blk_op,
        output cblk_full, cblk_blk_end
    );
endinterface

// File: rtl/blk_sched_rr_arbiter.sv
// rtl/blk_sched_rr_arbiter.sv - combinational round-robin pick starting just above the pointer
module blk_sched_rr_arbiter
    import blk_sched_pkg::*;
#(
    parameter int N_THREADS = 16,
    parameter int IDX_MSB   = msb_of(N_THREADS - 1)
) (
    input  logic [N_THREADS-1:0] req,
    input  logic [IDX_MSB:0]     ptr,
    output logic [IDX_MSB:0]     gnt_idx,
    output logic                 gnt_vld
);
    localparam int IW = IDX_MSB + 1;

    int idx;

    // Walk from the farthest offset down so the nearest request above ptr wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int i = N_THREADS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + 1 + i) % N_THREADS;
            if (req[idx]) begin
                gnt_idx = IW'(idx);
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/blk_sched.sv
// rtl/blk_sched.sv - round-robin, credit-gated thread scheduler in front of create_blk
// Optional watchdog on stuck blocks: define BLK_SCHED_WDOG_EN.
module blk_sched
    import blk_sched_pkg::*;
#(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = msb_of(N_THREADS - 1),
    parameter int N_BLK_SLOTS   = DEF_N_BLK_SLOTS,
    parameter int INIT_WAIT     = N_THREADS + 2,
    parameter int WDOG_CYCLES   = 1023
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_THREADS-1:0]  thread_rdy,
    input  logic [N_THREADS-1:0]  thread_new_comp,
    input  logic [BLK_OP_MSB:0]   thread_blk_op,
    blk_sched_if.master           cblk,
    input  logic                  slot_free,
    output logic [N_THREADS-1:0]  thread_done,
    output logic                  busy,
    output logic                  err
);
    localparam int IW = $clog2(INIT_WAIT + 1);

    blk_sched_state_t state, state_n;

    logic [IW-1:0]          init_cnt;
    logic [2:0]             credits, credits_n;
    logic [N_THREADS_MSB:0] ptr;
    logic [N_THREADS_MSB:0] gnt_idx;
    logic                   gnt_vld;
    logic                   credit_avail;
    logic                   take, issue, finish, wdog_fire;
    logic                   cred_ovf, stray_end;
    logic                   blk_start_q, new_comp_q;
    logic [N_THREADS_MSB:0] thread_num_q;
    logic [BLK_OP_MSB:0]    blk_op_q;
    logic                   wdog_hit;

    blk_sched_rr_arbiter #(
        .N_THREADS (N_THREADS),
        .IDX_MSB   (N_THREADS_MSB)
    ) u_arb (
        .req     (thread_rdy),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

`ifdef BLK_SCHED_WDOG_EN
    localparam int WW = ($clog2(WDOG_CYCLES + 1) > 10) ? $clog2(WDOG_CYCLES + 1) : 10;
    logic [WW-1:0] wdog_cnt;

    // Held at zero outside ACTIVE, so every entry to ACTIVE starts a fresh count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdog_cnt <= '0;
        end else if (state != ST_ACTIVE) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign wdog_hit = (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
    assign wdog_hit = 1'b0;
`endif

    // A slot released this cycle is usable for a grant in the same cycle.
    assign credit_avail = (credits != 3'd0) || slot_free;
    assign cred_ovf     = slot_free && !issue && (credits == 3'(N_BLK_SLOTS));
    assign stray_end    = cblk.cblk_blk_end && (state != ST_ACTIVE);

    always_comb begin
        credits_n = credits;
        case ({slot_free, issue})
            2'b10:   credits_n = (credits == 3'(N_BLK_SLOTS)) ? credits : credits + 3'd1;
            2'b01:   credits_n = credits - 3'd1;
            default: credits_n = credits;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_WAIT_INIT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        take      = 1'b0;
        issue     = 1'b0;
        finish    = 1'b0;
        wdog_fire = 1'b0;
        case (state)
            ST_WAIT_INIT: begin
                if (init_cnt == IW'(INIT_WAIT - 1)) begin
                    state_n = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (gnt_vld && credit_avail) begin
                    take    = 1'b1;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (!cblk.cblk_full) begin
                    issue   = 1'b1;
                    state_n = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cblk.cblk_blk_end) begin
                    finish  = 1'b1;
                    state_n = ST_SELECT;
                end else if (wdog_hit) begin
                    finish    = 1'b1;
                    wdog_fire = 1'b1;
                    state_n   = ST_SELECT;
                end
            end
            default: state_n = ST_WAIT_INIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            init_cnt     <= '0;
            credits      <= 3'(N_BLK_SLOTS);
            ptr          <= (N_THREADS_MSB + 1)'(N_THREADS - 1);
            thread_num_q <= '0;
            new_comp_q   <= 1'b0;
            blk_op_q     <= '0;
            blk_start_q  <= 1'b0;
            thread_done  <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            blk_start_q <= issue;
            thread_done <= finish ? ({{(N_THREADS - 1){1'b0}}, 1'b1} << thread_num_q) : '0;
            credits     <= credits_n;
            if (state == ST_WAIT_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (take) begin
                thread_num_q <= gnt_idx;
                ptr          <= gnt_idx;
                new_comp_q   <= thread_new_comp[gnt_idx];
            end
            if (issue) begin
                blk_op_q <= thread_blk_op;
                busy     <= 1'b1;
            end
            if (finish) begin
                busy <= 1'b0;
            end
            if (cred_ovf || stray_end || wdog_fire) begin
                err <= 1'b1;
            end
        end
    end

    assign cblk.blk_start  = blk_start_q;
    assign cblk.new_comp   = new_comp_q;
    assign cblk.thread_num = thread_num_q;
    assign cblk.blk_op     = blk_op_q;
endmodule

// File: tb/tb_blk_sched.sv
// tb/tb_blk_sched.sv - directed self-checking bench for blk_sched
module tb_blk_sched;
    import blk_sched_pkg::*;

    localparam int NT    = 16;
    localparam int IWAIT = 18;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NT-1:0]     thread_rdy;
    logic [NT-1:0]     thread_new_comp;
    logic [BLK_OP_MSB:0] thread_blk_op;
    logic              slot_free;
    logic [NT-1:0]     thread_done;
    logic              busy;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    blk_sched_if #(.THREAD_MSB(3), .OP_MSB(BLK_OP_MSB)) cblk ();

    blk_sched #(
        .N_THREADS   (NT),
        .N_BLK_SLOTS (2),
        .INIT_WAIT   (IWAIT),
        .WDOG_CYCLES (15)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .thread_rdy      (thread_rdy),
        .thread_new_comp (thread_new_comp),
        .thread_blk_op   (thread_blk_op),
        .cblk            (cblk.master),
        .slot_free       (slot_free),
        .thread_done     (thread_done),
        .busy            (busy),
        .err             (err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic do_reset();
        RST               = 1'b1;
        thread_rdy        = '0;
        thread_new_comp   = '0;
        thread_blk_op     = '0;
        slot_free         = 1'b0;
        cblk.cblk_full    = 1'b0;
        cblk.cblk_blk_end = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_start(input int bound, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < bound && !ok) begin
            @(negedge CLK);
            n++;
            if (cblk.blk_start) ok = 1'b1;
        end
    endtask

    task automatic end_block(input bit with_free);
        cblk.cblk_blk_end = 1'b1;
        slot_free         = with_free;
        @(negedge CLK);
        cblk.cblk_blk_end = 1'b0;
        slot_free         = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        RST               = 1'b1;
        thread_rdy        = 16'h0001;
        thread_new_comp   = 16'h0001;
        thread_blk_op     = 3'd5;
        slot_free         = 1'b0;
        cblk.cblk_full    = 1'b0;
        cblk.cblk_blk_end = 1'b0;
        repeat (2) @(negedge CLK);
        n_tests++; if (cblk.blk_start !== 1'b0) begin n_fail++; $display("FAIL rst_blk_start: got %b exp 0", cblk.blk_start); end
        n_tests++; if (cblk.new_comp !== 1'b0) begin n_fail++; $display("FAIL rst_new_comp: got %b exp 0", cblk.new_comp); end
        n_tests++; if (cblk.thread_num !== 4'd0) begin n_fail++; $display("FAIL rst_thread_num: got %0d exp 0", cblk.thread_num); end
        n_tests++; if (cblk.blk_op !== 3'd0) begin n_fail++; $display("FAIL rst_blk_op: got %0d exp 0", cblk.blk_op); end
        n_tests++; if (thread_done !== 16'h0000) begin n_fail++; $display("FAIL rst_thread_done: got %h exp 0000", thread_done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", err); end
        RST = 1'b0;
        // 18 init cycles (0..17), SELECT in 18, START in 19, blk_start seen in 20.
        wait_start(IWAIT + 8, n, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL first_start_timeout: got none exp start"); end
        n_tests++; if (n !== IWAIT + 2) begin n_fail++; $display("FAIL first_start_cycle: got %0d exp %0d", n, IWAIT + 2); end
        n_tests++; if (cblk.thread_num !== 4'd0) begin n_fail++; $display("FAIL first_thread_num: got %0d exp 0", cblk.thread_num); end
        n_tests++; if (cblk.new_comp !== 1'b1) begin n_fail++; $display("FAIL first_new_comp: got %b exp 1", cblk.new_comp); end
        n_tests++; if (cblk.blk_op !== 3'd5) begin n_fail++; $display("FAIL first_blk_op: got %0d exp 5", cblk.blk_op); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b exp 1", busy); end
        repeat (2) @(negedge CLK);
        end_block(1'b1);
        n_tests++; if (thread_done !== 16'h0001) begin n_fail++; $display("FAIL first_done: got %h exp 0001", thread_done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_busy_clr: got %b exp 0", busy); end
        thread_rdy = 16'h0000;
        @(negedge CLK);
        n_tests++; if (thread_done !== 16'h0000) begin n_fail++; $display("FAIL done_one_cycle: got %h exp 0000", thread_done); end
    endtask

    task automatic test_round_robin();
        int        n;
        bit        ok;
        logic [3:0]  exp_thr  [4] = '{4'd0, 4'd8, 4'd15, 4'd0};
        logic [15:0] exp_done [4] = '{16'h0001, 16'h0100, 16'h8000, 16'h0001};
        do_reset();
        thread_rdy    = 16'h8101;
        thread_blk_op = 3'd2;
        for (int i = 0; i < 4; i++) begin
            wait_start(IWAIT + 8, n, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_start_timeout[%0d]: got none exp start", i); end
            n_tests++; if (cblk.thread_num !== exp_thr[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d exp %0d", i, cblk.thread_num, exp_thr[i]); end
            repeat (5) @(negedge CLK);
            n_tests++; if (cblk.thread_num !== exp_thr[i]) begin n_fail++; $display("FAIL rr_num_stable[%0d]: got %0d exp %0d", i, cblk.thread_num, exp_thr[i]); end
            end_block(1'b1);
            n_tests++; if (thread_done !== exp_done[i]) begin n_fail++; $display("FAIL rr_done[%0d]: got %h exp %h", i, thread_done, exp_done[i]); end
            if (i == 3) thread_rdy = 16'h0000;
        end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b exp 0", err); end
    endtask

    task automatic test_credits();
        int n;
        int lat;
        bit ok;
        do_reset();
        thread_rdy = 16'h0001;
        for (int i = 0; i < 2; i++) begin
            wait_start(IWAIT + 8, n, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL cred_start[%0d]: got none exp start", i); end
            repeat (2) @(negedge CLK);
            end_block(1'b0);
            n_tests++; if (thread_done !== 16'h0001) begin n_fail++; $display("FAIL cred_done[%0d]: got %h exp 0001", i, thread_done); end
        end
        wait_start(12, n, ok);
        n_tests++; if (ok) begin n_fail++; $display("FAIL cred_stall: got start exp none"); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cred_stall_busy: got %b exp 0", busy); end
        slot_free = 1'b1;
        @(negedge CLK);
        slot_free = 1'b0;
        wait_start(6, n, ok);
        lat = n + 1;
        n_tests++; if (!ok || lat !== 2) begin n_fail++; $display("FAIL cred_refill_latency: got %0d exp 2", lat); end
        repeat (2) @(negedge CLK);
        end_block(1'b0);
        // Credits are 0 again: one slot_free grants, a second lands on the issue cycle.
        slot_free = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        slot_free = 1'b0;
        n_tests++; if (cblk.blk_start !== 1'b1) begin n_fail++; $display("FAIL start_with_free: got %b exp 1", cblk.blk_start); end
        repeat (2) @(negedge CLK);
        end_block(1'b0);
        wait_start(6, n, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL credit_kept: got none exp start"); end
        repeat (2) @(negedge CLK);
        end_block(1'b0);
        wait_start(10, n, ok);
        n_tests++; if (ok) begin n_fail++; $display("FAIL credit_zero_again: got start exp none"); end
        thread_rdy = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            slot_free = 1'b1;
            @(negedge CLK);
            slot_free = 1'b0;
            @(negedge CLK);
        end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL cred_full_no_err: got %b exp 0", err); end
        slot_free = 1'b1;
        @(negedge CLK);
        slot_free = 1'b0;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL cred_overflow_err: got %b exp 1", err); end
    endtask

    task automatic test_cblk_full();
        int n;
        bit ok;
        do_reset();
        cblk.cblk_full = 1'b1;
        thread_rdy     = 16'h0010;
        wait_start(IWAIT + 12, n, ok);
        n_tests++; if (ok) begin n_fail++; $display("FAIL full_blocks_start: got start exp none"); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy: got %b exp 0", busy); end
        cblk.cblk_full = 1'b0;
        @(negedge CLK);
        n_tests++; if (cblk.blk_start !== 1'b1) begin n_fail++; $display("FAIL start_after_full: got %b exp 1", cblk.blk_start); end
        n_tests++; if (cblk.thread_num !== 4'd4) begin n_fail++; $display("FAIL full_thread_num: got %0d exp 4", cblk.thread_num); end
        repeat (2) @(negedge CLK);
        end_block(1'b1);
        n_tests++; if (thread_done !== 16'h0010) begin n_fail++; $display("FAIL full_done: got %h exp 0010", thread_done); end
        thread_rdy = 16'h0000;
        @(negedge CLK);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL pre_stray_err: got %b exp 0", err); end
        cblk.cblk_blk_end = 1'b1;
        @(negedge CLK);
        cblk.cblk_blk_end = 1'b0;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL stray_end_err: got %b exp 1", err); end
        @(negedge CLK);
        n_tests++; if (thread_done !== 16'h0000) begin n_fail++; $display("FAIL stray_end_done: got %h exp 0000", thread_done); end
    endtask

    task automatic test_stuck_block();
        int n;
        bit ok;
        do_reset();
        thread_rdy = 16'h0003;
        wait_start(IWAIT + 8, n, ok);
        n_tests++; if (!ok || cblk.thread_num !== 4'd0) begin n_fail++; $display("FAIL stuck_first: got ok=%b num=%0d exp ok=1 num=0", ok, cblk.thread_num); end
`ifdef BLK_SCHED_WDOG_EN
        n = 0;
        while (thread_done == 16'h0000 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        n_tests++; if (n !== 15) begin n_fail++; $display("FAIL wdog_latency: got %0d exp 15", n); end
        n_tests++; if (thread_done !== 16'h0001) begin n_fail++; $display("FAIL wdog_done: got %h exp 0001", thread_done); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL wdog_err: got %b exp 1", err); end
        thread_rdy = 16'h0002;
        wait_start(6, n, ok);
        n_tests++; if (!ok || cblk.thread_num !== 4'd1) begin n_fail++; $display("FAIL wdog_next: got ok=%b num=%0d exp ok=1 num=1", ok, cblk.thread_num); end
        repeat (2) @(negedge CLK);
        end_block(1'b1);
        n_tests++; if (thread_done !== 16'h0002) begin n_fail++; $display("FAIL wdog_next_done: got %h exp 0002", thread_done); end
`else
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (thread_done != 16'h0000) ok = 1'b1;
        end
        n_tests++; if (ok) begin n_fail++; $display("FAIL nowdog_done: got pulse exp none"); end
        n_tests++; if (busy !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL nowdog_state: got busy=%b err=%b exp busy=1 err=0", busy, err); end
        end_block(1'b1);
        n_tests++; if (thread_done !== 16'h0001) begin n_fail++; $display("FAIL nowdog_done_late: got %h exp 0001", thread_done); end
`endif
        thread_rdy = 16'h0000;
        @(negedge CLK);
    endtask

    task automatic test_reset_abort();
        int n;
        bit ok;
        do_reset();
        thread_rdy = 16'h0040;
        wait_start(IWAIT + 8, n, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_start: got none exp start"); end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        n_tests++; if (busy !== 1'b0 || thread_done !== 16'h0000) begin n_fail++; $display("FAIL abort_clear: got busy=%b done=%h exp 0/0000", busy, thread_done); end
        RST        = 1'b0;
        thread_rdy = 16'h0000;
        @(negedge CLK);
        n_tests++; if (thread_done !== 16'h0000) begin n_fail++; $display("FAIL abort_no_done: got %h exp 0000", thread_done); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credits();
        test_cblk_full();
        test_stuck_block();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
